// File: rtl/pipe_phy_model_if.sv
// PIPE MAC/PHY signal bundle. The rp modport is the PHY side and the mp modport is the MAC side.
interface pipe_if;
   logic [7:0] txdata;
   logic       txdatak;
   logic       txelecidle;
   logic       txdetectrx;
   logic       txcompl;
   logic       rxpolarity;
   logic       txswing;
   logic       txdeemph;
   logic [1:0] powerdown;
   logic [2:0] txmargin;
   logic [2:0] eidleinfersel;
   logic       phystatus;
   logic [7:0] rxdata;
   logic       rxdatak;
   logic       rxelecidle;
   logic       rxvalid;
   logic [2:0] rxstatus;

   modport rp (
      input  txdata, txdatak, txelecidle, txdetectrx, txcompl, rxpolarity,
             txswing, txdeemph, powerdown, txmargin, eidleinfersel,
      output phystatus, rxdata, rxdatak, rxelecidle, rxvalid, rxstatus
   );

   modport mp (
      output txdata, txdatak, txelecidle, txdetectrx, txcompl, rxpolarity,
             txswing, txdeemph, powerdown, txmargin, eidleinfersel,
      input  phystatus, rxdata, rxdatak, rxelecidle, rxvalid, rxstatus
   );
endinterface

// File: rtl/pipe_phy_model.sv
// Behavioural PIPE PHY: handles the power-state handshake and receiver detection, and provides the 1-cycle rx/tx datapaths.
// Define PIPE_PHY_POLARITY_EN to make rxpolarity invert the received data.
module pipe_phy_model #(
   parameter int RST_DLY = 16,
   parameter int PD_DLY  = 4,
   parameter int DET_DLY = 8
) (
   input  logic       clk,
   input  logic       rst,
   pipe_if.rp         pipe,
   input  logic [7:0] lnk_rxdata,
   input  logic       lnk_rxdatak,
   input  logic       lnk_rxelecidle,
   input  logic       lnk_present,
   output logic [7:0] lnk_txdata,
   output logic       lnk_txdatak,
   output logic       lnk_txelecidle
);

   localparam int RST_E = (RST_DLY < 1) ? 1 : RST_DLY;
   localparam int PD_E  = (PD_DLY  < 1) ? 1 : PD_DLY;
   localparam int DET_E = (DET_DLY < 1) ? 1 : DET_DLY;
   localparam int MAX_A = (RST_E > PD_E) ? RST_E : PD_E;
   localparam int MAX_E = (MAX_A > DET_E) ? MAX_A : DET_E;
   localparam int CW    = $clog2(MAX_E + 1);

   localparam logic [CW-1:0] RST_LD  = CW'(RST_E);
   localparam logic [CW-1:0] PD_LD   = CW'(PD_E);
   localparam logic [CW-1:0] DET_LD  = CW'(DET_E);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [1:0] P0 = 2'b00;
   localparam logic [1:0] P1 = 2'b10;

   typedef enum logic [2:0] {
      RST_WAIT = 3'd0,
      IDLE     = 3'd1,
      PD_WAIT  = 3'd2,
      DET_WAIT = 3'd3,
      DET_HOLD = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    pd_q, pd_d;
   logic          phystatus_q, phystatus_d;
   logic [2:0]    rxstatus_q, rxstatus_d;

   logic          pd_chg;
   logic          cnt_last;

   assign pd_chg   = (pipe.powerdown != pd_q);
   assign cnt_last = (cnt_q == CNT_ONE);

   // State register; phystatus/rxstatus are registered so pulses are glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RST_WAIT;
         cnt_q       <= RST_LD;
         pd_q        <= P1;
         phystatus_q <= 1'b1;
         rxstatus_q  <= 3'b000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pd_q        <= pd_d;
         phystatus_q <= phystatus_d;
         rxstatus_q  <= rxstatus_d;
      end
   end

   // Next-state logic: a powerdown change always outranks detection and expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pd_d    = pd_q;
      case (state_q)
         RST_WAIT: begin
            if (cnt_last) begin
               state_d = IDLE;
               pd_d    = pipe.powerdown;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         IDLE: begin
            if (pd_chg) begin
               pd_d    = pipe.powerdown;
               cnt_d   = PD_LD;
               state_d = PD_WAIT;
            end else if (pipe.txdetectrx && (pd_q == P1)) begin
               cnt_d   = DET_LD;
               state_d = DET_WAIT;
            end
         end
         PD_WAIT: begin
            if (pd_chg) begin
               pd_d  = pipe.powerdown;
               cnt_d = PD_LD;
            end else if (cnt_last) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DET_WAIT: begin
            if (pd_chg) begin
               pd_d    = pipe.powerdown;
               cnt_d   = PD_LD;
               state_d = PD_WAIT;
            end else if (cnt_last) begin
               state_d = DET_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DET_HOLD: begin
            if (pd_chg) begin
               pd_d    = pipe.powerdown;
               cnt_d   = PD_LD;
               state_d = PD_WAIT;
            end else if (!pipe.txdetectrx) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = RST_WAIT;
            cnt_d   = RST_LD;
         end
      endcase
   end

   // Output logic: computes the values phystatus/rxstatus take after this edge.
   always_comb begin
      phystatus_d = 1'b0;
      rxstatus_d  = 3'b000;
      case (state_q)
         RST_WAIT: phystatus_d = !cnt_last;
         PD_WAIT:  phystatus_d = !pd_chg && cnt_last;
         DET_WAIT: begin
            if (!pd_chg && cnt_last) begin
               phystatus_d = 1'b1;
               rxstatus_d  = lnk_present ? 3'b011 : 3'b000;
            end
         end
         default: begin
            phystatus_d = 1'b0;
            rxstatus_d  = 3'b000;
         end
      endcase
   end

   assign pipe.phystatus = phystatus_q;
   assign pipe.rxstatus  = rxstatus_q;

   logic [7:0] rx_sym;
   logic       rxvalid_q, rxvalid_d;
   logic [7:0] rxdata_q, rxdata_d;
   logic       rxdatak_q, rxdatak_d;
   logic       rxelecidle_q;
   logic [7:0] ltxdata_q, ltxdata_d;
   logic       ltxdatak_q, ltxdatak_d;
   logic       ltxidle_q, ltxidle_d;

`ifdef PIPE_PHY_POLARITY_EN
   assign rx_sym = pipe.rxpolarity ? ~lnk_rxdata : lnk_rxdata;
`else
   assign rx_sym = lnk_rxdata;
`endif

   // Datapaths follow the power state that has been latched, not the raw powerdown request.
   always_comb begin
      rxvalid_d  = (pd_q == P0) && !lnk_rxelecidle;
      rxdata_d   = rxvalid_d ? rx_sym : 8'h00;
      rxdatak_d  = rxvalid_d ? lnk_rxdatak : 1'b0;
      ltxidle_d  = pipe.txelecidle || (pd_q != P0);
      ltxdata_d  = ltxidle_d ? 8'h00 : pipe.txdata;
      ltxdatak_d = ltxidle_d ? 1'b0 : pipe.txdatak;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxvalid_q    <= 1'b0;
         rxdata_q     <= 8'h00;
         rxdatak_q    <= 1'b0;
         rxelecidle_q <= 1'b1;
         ltxdata_q    <= 8'h00;
         ltxdatak_q   <= 1'b0;
         ltxidle_q    <= 1'b1;
      end else begin
         rxvalid_q    <= rxvalid_d;
         rxdata_q     <= rxdata_d;
         rxdatak_q    <= rxdatak_d;
         rxelecidle_q <= lnk_rxelecidle;
         ltxdata_q    <= ltxdata_d;
         ltxdatak_q   <= ltxdatak_d;
         ltxidle_q    <= ltxidle_d;
      end
   end

   assign pipe.rxvalid    = rxvalid_q;
   assign pipe.rxdata     = rxdata_q;
   assign pipe.rxdatak    = rxdatak_q;
   assign pipe.rxelecidle = rxelecidle_q;
   assign lnk_txdata      = ltxdata_q;
   assign lnk_txdatak     = ltxdatak_q;
   assign lnk_txelecidle  = ltxidle_q;

endmodule

// File: tb/tb_pipe_phy_model.sv
// Directed bench for pipe_phy_model: uses a datapath vector table plus hand-written handshake sequences.
module tb_pipe_phy_model;
   logic       clk;
   logic       rst;
   logic [7:0] lnk_rxdata;
   logic       lnk_rxdatak;
   logic       lnk_rxelecidle;
   logic       lnk_present;
   logic [7:0] lnk_txdata;
   logic       lnk_txdatak;
   logic       lnk_txelecidle;

   int errors = 0;
   int checks = 0;

   pipe_if pif ();

   pipe_phy_model dut (
      .clk            (clk),
      .rst            (rst),
      .pipe           (pif),
      .lnk_rxdata     (lnk_rxdata),
      .lnk_rxdatak    (lnk_rxdatak),
      .lnk_rxelecidle (lnk_rxelecidle),
      .lnk_present    (lnk_present),
      .lnk_txdata     (lnk_txdata),
      .lnk_txdatak    (lnk_txdatak),
      .lnk_txelecidle (lnk_txelecidle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rxd;
      logic       rxk;
      logic       rxei;
      logic       pol;
      logic [7:0] txd;
      logic       txk;
      logic       txei;
      logic [7:0] e_rxd;
      logic       e_rxk;
      logic       e_rxv;
      logic       e_rxei;
      logic [7:0] e_ltxd;
      logic       e_ltxk;
      logic       e_ltxei;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Runs n clocks. Expected phystatus pulses occur at edges pa/pb (-1 means none).
   // If chg_at >= 0, powerdown is set to chg_pd just before that edge.
   task automatic window(input int n, input int pa, input logic [2:0] sa,
                         input int pb, input logic [2:0] sb,
                         input int chg_at, input logic [1:0] chg_pd, input string nm);
      logic       e_ps;
      logic [2:0] e_st;
      for (int k = 0; k < n; k++) begin
         if (k == chg_at) pif.powerdown = chg_pd;
         @(posedge clk);
         #1;
         e_ps = 1'b0;
         e_st = 3'b000;
         if (k == pa) begin e_ps = 1'b1; e_st = sa; end
         if (k == pb) begin e_ps = 1'b1; e_st = sb; end
         chk($sformatf("%s phystatus k=%0d", nm, k), 32'(pif.phystatus), 32'(e_ps));
         chk($sformatf("%s rxstatus k=%0d", nm, k), 32'(pif.rxstatus), 32'(e_st));
      end
      $display("window %s: %0d cycles done", nm, n);
   endtask

   task automatic rst_window(input string nm);
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s phystatus k=%0d", nm, k), 32'(pif.phystatus), (k < 16) ? 32'd1 : 32'd0);
         chk($sformatf("%s rxstatus k=%0d", nm, k), 32'(pif.rxstatus), 32'd0);
      end
      $display("reset window %s done", nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'hBC, 1'b1, 1'b0, 1'b0, 8'h4A, 1'b0, 1'b0,
                  8'hBC, 1'b1, 1'b1, 1'b0, 8'h4A, 1'b0, 1'b0};
`ifdef PIPE_PHY_POLARITY_EN
      vecs[1] = '{8'hBC, 1'b1, 1'b0, 1'b1, 8'h4A, 1'b0, 1'b1,
                  8'h43, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1,
                  8'hC3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
`else
      vecs[1] = '{8'hBC, 1'b1, 1'b0, 1'b1, 8'h4A, 1'b0, 1'b1,
                  8'hBC, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1,
                  8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
`endif
      vecs[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0,
                  8'h00, 1'b0, 1'b0, 1'b1, 8'hBC, 1'b1, 1'b0};
      vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0,
                  8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

      rst               = 1'b1;
      pif.powerdown     = 2'b10;
      pif.txdetectrx    = 1'b0;
      pif.txdata        = 8'h4A;
      pif.txdatak       = 1'b1;
      pif.txelecidle    = 1'b0;
      pif.rxpolarity    = 1'b0;
      pif.txcompl       = 1'b0;
      pif.txswing       = 1'b0;
      pif.txdeemph      = 1'b0;
      pif.txmargin      = 3'b000;
      pif.eidleinfersel = 3'b000;
      lnk_rxdata        = 8'hBC;
      lnk_rxdatak       = 1'b1;
      lnk_rxelecidle    = 1'b0;
      lnk_present       = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("reset phystatus", 32'(pif.phystatus), 32'd1);
      chk("reset rxvalid", 32'(pif.rxvalid), 32'd0);
      chk("reset rxdata", 32'(pif.rxdata), 32'd0);
      chk("reset rxdatak", 32'(pif.rxdatak), 32'd0);
      chk("reset rxstatus", 32'(pif.rxstatus), 32'd0);
      chk("reset rxelecidle", 32'(pif.rxelecidle), 32'd1);
      chk("reset lnk_txdata", 32'(lnk_txdata), 32'd0);
      chk("reset lnk_txdatak", 32'(lnk_txdatak), 32'd0);
      chk("reset lnk_txelecidle", 32'(lnk_txelecidle), 32'd1);
      $display("reset values checked");

      @(negedge clk);
      rst = 1'b0;
      rst_window("rst_release");

      // Receiver detection in P1: first with the far end present, then with it absent.
      pif.txdetectrx = 1'b1;
      lnk_present    = 1'b1;
      window(12, 8, 3'b011, -1, 3'b000, -1, 2'b00, "det_present");
      pif.txdetectrx = 1'b0;
      window(2, -1, 3'b000, -1, 3'b000, -1, 2'b00, "det_drop1");
      pif.txdetectrx = 1'b1;
      lnk_present    = 1'b0;
      window(12, 8, 3'b000, -1, 3'b000, -1, 2'b00, "det_absent");
      pif.txdetectrx = 1'b0;
      window(2, -1, 3'b000, -1, 3'b000, -1, 2'b00, "det_drop2");

      pif.powerdown = 2'b00;
      window(8, 4, 3'b000, -1, 3'b000, -1, 2'b00, "pd_to_p0");

      for (int i = 0; i < 5; i++) begin
         lnk_rxdata     = vecs[i].rxd;
         lnk_rxdatak    = vecs[i].rxk;
         lnk_rxelecidle = vecs[i].rxei;
         pif.rxpolarity = vecs[i].pol;
         pif.txdata     = vecs[i].txd;
         pif.txdatak    = vecs[i].txk;
         pif.txelecidle = vecs[i].txei;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d rxdata", i), 32'(pif.rxdata), 32'(vecs[i].e_rxd));
         chk($sformatf("vec%0d rxdatak", i), 32'(pif.rxdatak), 32'(vecs[i].e_rxk));
         chk($sformatf("vec%0d rxvalid", i), 32'(pif.rxvalid), 32'(vecs[i].e_rxv));
         chk($sformatf("vec%0d rxelecidle", i), 32'(pif.rxelecidle), 32'(vecs[i].e_rxei));
         chk($sformatf("vec%0d lnk_txdata", i), 32'(lnk_txdata), 32'(vecs[i].e_ltxd));
         chk($sformatf("vec%0d lnk_txdatak", i), 32'(lnk_txdatak), 32'(vecs[i].e_ltxk));
         chk($sformatf("vec%0d lnk_txelecidle", i), 32'(lnk_txelecidle), 32'(vecs[i].e_ltxei));
         $display("vec%0d applied: rxd=%0h txd=%0h", i, vecs[i].rxd, vecs[i].txd);
      end
      pif.rxpolarity = 1'b0;

      // Detection is not performed outside P1.
      pif.txdetectrx = 1'b1;
      window(12, -1, 3'b000, -1, 3'b000, -1, 2'b00, "det_in_p0");
      pif.txdetectrx = 1'b0;

      // A second powerdown change restarts the wait, so only one pulse occurs.
      pif.powerdown = 2'b10;
      window(10, 6, 3'b000, -1, 3'b000, 2, 2'b11, "pd_restart");
      pif.powerdown = 2'b10;
      window(8, 4, 3'b000, -1, 3'b000, -1, 2'b00, "pd_to_p1");

      // A powerdown change during detection aborts it.
      pif.txdetectrx = 1'b1;
      lnk_present    = 1'b1;
      window(14, 7, 3'b000, -1, 3'b000, 3, 2'b00, "det_abort");
      pif.txdetectrx = 1'b0;
      window(2, -1, 3'b000, -1, 3'b000, -1, 2'b00, "abort_drop");

      // A powerdown change and detect request arriving together: powerdown is handled first.
      pif.powerdown  = 2'b10;
      pif.txdetectrx = 1'b1;
      window(16, 4, 3'b000, 13, 3'b011, -1, 2'b00, "pd_and_det");
      pif.txdetectrx = 1'b0;
      window(2, -1, 3'b000, -1, 3'b000, -1, 2'b00, "pd_det_drop");

      lnk_rxelecidle = 1'b0;
      lnk_rxdata     = 8'h5A;
      pif.txelecidle = 1'b0;
      pif.txdata     = 8'h4A;
      @(posedge clk);
      #1;
      chk("p1 rxvalid", 32'(pif.rxvalid), 32'd0);
      chk("p1 rxdata", 32'(pif.rxdata), 32'd0);
      chk("p1 rxelecidle", 32'(pif.rxelecidle), 32'd0);
      chk("p1 lnk_txelecidle", 32'(lnk_txelecidle), 32'd1);
      chk("p1 lnk_txdata", 32'(lnk_txdata), 32'd0);
      $display("p1 datapath checked");

      // Asserting reset mid-detection cancels the pending pulse.
      pif.txdetectrx = 1'b1;
      window(4, -1, 3'b000, -1, 3'b000, -1, 2'b00, "det_before_rst");
      rst = 1'b1;
      #1;
      chk("async rst phystatus", 32'(pif.phystatus), 32'd1);
      chk("async rst lnk_txelecidle", 32'(lnk_txelecidle), 32'd1);
      pif.txdetectrx = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rst_window("rst_abort");
      window(12, -1, 3'b000, -1, 3'b000, -1, 2'b00, "post_rst_quiet");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
